// File: rtl/bka_sub_pipe_32bit.sv
// Three-stage Brent-Kung subtractor, Diff = A - B - Bin, computed as A + ~B + ~Bin.
// Full valid/ready backpressure; results leave in acceptance order.
module bka_sub_pipe_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int LG = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic             c0;
        logic             am;
        logic             bm;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] gp;
        logic             c0;
        logic             am;
        logic             bm;
    } s2_t;

    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    s1_t  s1;
    s2_t  s2;

    assign adv3      = !v3 | out_ready;
    assign adv2      = !v2 | adv3;
    assign adv1      = !v1 | adv2;
    assign in_ready  = !v1 | adv1;
    assign out_valid = v3;

    // Up-sweep: node i gathers span of 2^l bits ending at i.
    logic [WIDTH-1:0] ug, up;
    always_comb begin
        ug = s1.g;
        up = s1.p;
        for (int l = 1; l <= LG; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    ug[i] = ug[i] | (up[i] & ug[i - (1 << (l - 1))]);
                    up[i] = up[i] & up[i - (1 << (l - 1))];
                end
            end
        end
    end

    // Down-sweep fills in the remaining prefixes [0..i].
    logic [WIDTH-1:0] dg, dp;
    always_comb begin
        dg = s2.gg;
        dp = s2.gp;
        for (int l = LG - 1; l >= 1; l--) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i + 1) % (1 << l)) == (1 << (l - 1))
                    && i >= 3 * (1 << (l - 1)) - 1) begin
                    dg[i] = dg[i] | (dp[i] & dg[i - (1 << (l - 1))]);
                    dp[i] = dp[i] & dp[i - (1 << (l - 1))];
                end
            end
        end
    end

    logic [WIDTH-1:0] carries, dsum;
    logic             cout;
    assign carries = {dg[WIDTH-2:0] | (dp[WIDTH-2:0] & {(WIDTH-1){s2.c0}}), s2.c0};
    assign cout    = dg[WIDTH-1] | (dp[WIDTH-1] & s2.c0);
    assign dsum    = s2.p ^ carries;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1    <= in_valid;
            s1.p  <= A ^ ~B;
            s1.g  <= A & ~B;
            s1.c0 <= ~Bin;
            s1.am <= A[WIDTH-1];
            s1.bm <= B[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (adv2) begin
            v2    <= v1;
            s2.p  <= s1.p;
            s2.gg <= ug;
            s2.gp <= up;
            s2.c0 <= s1.c0;
            s2.am <= s1.am;
            s2.bm <= s1.bm;
        end
    end

    // Output payload loads only with real data so it reads 0 until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3   <= 1'b0;
            Diff <= '0;
            Bout <= 1'b0;
            Ovf  <= 1'b0;
            Zero <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                Diff <= dsum;
                Bout <= ~cout;
                Ovf  <= (s2.am != s2.bm) & (dsum[WIDTH-1] != s2.am);
                Zero <= ~|dsum;
            end
        end
    end

endmodule
